ux607_gnrl_icb32tobyte_split: RTL and testbench
===============================================

# ux607_gnrl_icb32tobyte_split

Splits 32-bit ICB word and halfword accesses into a sequence of single-byte ICB accesses, one per active lane, for byte-wide peripheral bridges. It sits directly upstream of the ICB-to-8-bit-Wishbone bridge in the subsystem. That bridge carries only one byte lane per transfer and returns read data lane-aligned. Read bytes from all beats are merged into one 32-bit response. Write beats are issued only for lanes whose mask bit is set.

## Interface
- AW, 32, address width of both ICB ports.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_icb_cmd_valid / i_icb_cmd_ready  in/out  1/1  upstream command handshake.
- i_icb_cmd_read  input  1  1 = read, 0 = write.
- i_icb_cmd_addr  input  AW  byte address.
- i_icb_cmd_wdata  input  32  write data, lane-positioned.
- i_icb_cmd_wmask  input  4  byte write enables.
- i_icb_cmd_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as 2.
- i_icb_rsp_valid / i_icb_rsp_ready  out/in  1/1  upstream response handshake.
- i_icb_rsp_err  output  1  OR of all beat errors.
- i_icb_rsp_rdata  output  32  merged read data; 0 for writes.
- o_icb_cmd_valid / o_icb_cmd_ready  out/in  1/1  downstream byte command handshake.
- o_icb_cmd_read  output  1  copy of the latched read flag.
- o_icb_cmd_addr  output  AW  byte address of the current beat.
- o_icb_cmd_wdata  output  32  latched upstream wdata, unchanged.
- o_icb_cmd_wmask  output  4  one-hot mask for the current lane.
- o_icb_cmd_size  output  2  constant 0.
- o_icb_rsp_valid  input  1  downstream beat response; there is no ready, so it is always consumed.
- o_icb_rsp_err  input  1  downstream beat error.
- o_icb_rsp_rdata  input  32  downstream read data, lane-aligned.

## Operation
- **States:** IDLE, CMD, WRSP, RESP. Reset puts the block in IDLE.
- **Outputs decoded from state:**
  - i_icb_cmd_ready = (IDLE).
  - o_icb_cmd_valid = (CMD).
  - i_icb_rsp_valid = (RESP).
- **Accept (IDLE with i_icb_cmd_valid):**
  - Latch read, wdata, size.
  - base = addr with the low log2(bytes) bits cleared; bytes = 1, 2 or 4.
  - window = lanes base[1:0] .. base[1:0]+bytes-1.
  - Lane enable (en) = window for reads, window AND wmask for writes.
  - Clear the rdata accumulator and the error flag.
  - If en == 0, go to RESP; otherwise set lane = lowest set bit of en and go to CMD.
- **Current beat outputs:**
  - o_icb_cmd_addr = {base[AW-1:2], lane}.
  - o_icb_cmd_wmask = 1 << lane.
- **CMD:**
  - cmd_ready together with rsp_valid: beat done this cycle.
  - cmd_ready without rsp_valid: go to WRSP.
  - o_icb_rsp_valid without a command handshake is ignored.
- **WRSP:** beat done on o_icb_rsp_valid.
- **Beat done:**
  - acc[8*lane+:8] = o_icb_rsp_rdata[8*lane+:8] for reads; other bytes of the downstream rdata are discarded.
  - err |= o_icb_rsp_err.
  - Clear the lane's bit in en.
  - If any enabled lane remains, move to the next higher one and go to CMD; otherwise go to RESP.
- **RESP:** drive acc and err; on i_icb_rsp_ready go to IDLE.
- **Error behaviour:** an error does not abort the sequence; all enabled lanes are still issued.
- **Registers:** all latched fields, acc, err and lane are registers.
  - Reset value of all of these is 0.
  - Output reset values: i_icb_cmd_ready = 1, every valid = 0, every data, address and mask output = 0.
- **Reset mid-operation:** returns to IDLE immediately. The in-flight upstream transaction is dropped and produces no response; any downstream beat in flight is abandoned.

## Timing
- Command accepted at cycle 0.
- With a downstream that acks combinationally (cmd_ready = rsp_valid in the same cycle), beat k occupies cycle k+1 and i_icb_rsp_valid rises at cycle N+1, where N is the number of enabled lanes.
- Throughput: one byte beat per cycle; one upstream transaction in flight.
- Back-to-back upstream commands: a new command can be accepted no earlier than the cycle after the response handshake.
- All outputs hold stable while their valid is asserted and ready is low.

## Test plan
- **Word read, misaligned:** size 2 at 0x1000_0002; downstream returns byte 0x11/0x22/0x33/0x44 on lanes 0..3.
  - Beats at 0x1000_0000..0x1000_0003 with wmask 0001, 0010, 0100, 1000.
  - rdata = 0x4433_2211; rsp_valid at cycle 5.
- **Halfword write:** size 1 at 0x06, wdata 0xAABB_CCDD, wmask 1100.
  - Two beats: 0x06 with mask 0100, then 0x07 with mask 1000; wdata is 0xAABB_CCDD on both.
- **Sparse word write and empty write:**
  - wmask 1001 gives two beats at lanes 0 and 3.
  - wmask 0000 gives no downstream beats and a response at cycle 1 with err = 0.
- **Byte read at 0x03:**
  - One beat at 0x03.
  - Downstream rdata 0xFF5A_FFFF gives response rdata 0xFF00_0000 with the other bytes masked.
- **Error and stall:**
  - Word read with err = 1 on beat 2: all 4 beats are still issued and the response has err = 1.
  - A downstream cmd_ready low for 3 cycles holds addr/mask stable; WRSP is exercised by a 2-cycle rsp delay.
- **Backpressure and reset:**
  - i_icb_rsp_ready low for 4 cycles holds rsp_valid and rdata, with cmd_ready = 0.
  - rst asserted during beat 2: all valids drop to 0 asynchronously, and the next command starts cleanly from lane 0.

Source files
------------

// File: rtl/ux607_gnrl_icb32tobyte_split.sv
// ux607_gnrl_icb32tobyte_split
// Breaks a 32-bit ICB byte/halfword/word access into a sequence of single-byte
// ICB beats, one per enabled lane, for byte-wide peripheral bridges. Read bytes
// from every beat are merged lane-aligned into one 32-bit response and beat
// errors are ORed together. Only one upstream transaction is in flight.
module ux607_gnrl_icb32tobyte_split #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,

  // Upstream 32-bit command channel
  input  logic          i_icb_cmd_valid,
  output logic          i_icb_cmd_ready,
  input  logic          i_icb_cmd_read,
  input  logic [AW-1:0] i_icb_cmd_addr,
  input  logic [31:0]   i_icb_cmd_wdata,
  input  logic [3:0]    i_icb_cmd_wmask,
  input  logic [1:0]    i_icb_cmd_size,

  // Upstream 32-bit response channel
  output logic          i_icb_rsp_valid,
  input  logic          i_icb_rsp_ready,
  output logic          i_icb_rsp_err,
  output logic [31:0]   i_icb_rsp_rdata,

  // Downstream byte command channel
  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic          o_icb_cmd_read,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic [31:0]   o_icb_cmd_wdata,
  output logic [3:0]    o_icb_cmd_wmask,
  output logic [1:0]    o_icb_cmd_size,

  // Downstream byte response channel (always consumed, no ready)
  input  logic          o_icb_rsp_valid,
  input  logic          o_icb_rsp_err,
  input  logic [31:0]   o_icb_rsp_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWrsp,
    StResp
  } state_e;

  // Lowest set bit of a 4-lane mask; callers guarantee the mask is non-zero.
  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    if (m[0]) begin
      return 2'd0;
    end else if (m[1]) begin
      return 2'd1;
    end else if (m[2]) begin
      return 2'd2;
    end
    return 2'd3;
  endfunction

  state_e        state_q, state_d;
  logic          read_q, read_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW-3:0] base_hi_q, base_hi_d;
  logic [3:0]    en_q, en_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   acc_q, acc_d;
  logic          err_q, err_d;

  logic [3:0]    window;
  logic [3:0]    accept_en;
  logic [3:0]    lane_oh;
  logic [3:0]    en_left;
  logic          beat_done;

  // Lane window of the incoming access. The base is the address aligned to the
  // access size, so only its low two bits matter for the window; the size
  // itself is not needed after accept, the resulting lane set is latched.
  always_comb begin
    window = 4'b0000;
    unique case (i_icb_cmd_size)
      2'd0:    window = 4'b0001 << i_icb_cmd_addr[1:0];
      2'd1:    window = 4'b0011 << {i_icb_cmd_addr[1], 1'b0};
      default: window = 4'b1111;
    endcase
    accept_en = i_icb_cmd_read ? window : (window & i_icb_cmd_wmask);
  end

  assign lane_oh = 4'b0001 << lane_q;
  assign en_left = en_q & ~lane_oh;

  // Next-state logic: accept, per-beat sequencing and response hand-off.
  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    wdata_d   = wdata_q;
    base_hi_d = base_hi_q;
    en_d      = en_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    err_d     = err_q;
    beat_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_icb_cmd_valid) begin
          read_d    = i_icb_cmd_read;
          wdata_d   = i_icb_cmd_wdata;
          base_hi_d = i_icb_cmd_addr[AW-1:2];
          en_d      = accept_en;
          acc_d     = 32'h0;
          err_d     = 1'b0;
          if (accept_en == 4'b0000) begin
            state_d = StResp;
          end else begin
            lane_d  = lowest_lane(accept_en);
            state_d = StCmd;
          end
        end
      end
      StCmd: begin
        // A response without a command handshake belongs to nothing; ignore it.
        if (o_icb_cmd_ready) begin
          if (o_icb_rsp_valid) begin
            beat_done = 1'b1;
          end else begin
            state_d = StWrsp;
          end
        end
      end
      StWrsp: begin
        if (o_icb_rsp_valid) begin
          beat_done = 1'b1;
        end
      end
      StResp: begin
        if (i_icb_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Errors never abort the sequence; every enabled lane is still issued.
    if (beat_done) begin
      if (read_q) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_oh[i]) begin
            acc_d[8*i +: 8] = o_icb_rsp_rdata[8*i +: 8];
          end
        end
      end
      err_d = err_q | o_icb_rsp_err;
      en_d  = en_left;
      if (en_left != 4'b0000) begin
        lane_d  = lowest_lane(en_left);
        state_d = StCmd;
      end else begin
        state_d = StResp;
      end
    end
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      read_q    <= 1'b0;
      wdata_q   <= 32'h0;
      base_hi_q <= '0;
      en_q      <= 4'b0000;
      lane_q    <= 2'd0;
      acc_q     <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      wdata_q   <= wdata_d;
      base_hi_q <= base_hi_d;
      en_q      <= en_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    i_icb_cmd_ready = (state_q == StIdle);
    o_icb_cmd_valid = (state_q == StCmd);
    i_icb_rsp_valid = (state_q == StResp);
  end

  // Beat and response data; the lane mask is zero outside a command beat so
  // it reads as all-zero after reset.
  always_comb begin
    o_icb_cmd_read  = read_q;
    o_icb_cmd_addr  = {base_hi_q, lane_q};
    o_icb_cmd_wdata = wdata_q;
    o_icb_cmd_wmask = (state_q == StCmd) ? lane_oh : 4'b0000;
    o_icb_cmd_size  = 2'd0;
    i_icb_rsp_rdata = acc_q;
    i_icb_rsp_err   = err_q;
  end

endmodule

// File: tb/tb_ux607_gnrl_icb32tobyte_split.sv
// Bench for ux607_gnrl_icb32tobyte_split: a directed vector table, a few
// hand-built corner sequences and randomized transactions, all checked against
// a lane-list reference model of the split.
module tb_ux607_gnrl_icb32tobyte_split;

  logic        clk;
  logic        rst;
  logic        i_icb_cmd_valid;
  logic        i_icb_cmd_ready;
  logic        i_icb_cmd_read;
  logic [31:0] i_icb_cmd_addr;
  logic [31:0] i_icb_cmd_wdata;
  logic [3:0]  i_icb_cmd_wmask;
  logic [1:0]  i_icb_cmd_size;
  logic        i_icb_rsp_valid;
  logic        i_icb_rsp_ready;
  logic        i_icb_rsp_err;
  logic [31:0] i_icb_rsp_rdata;
  logic        o_icb_cmd_valid;
  logic        o_icb_cmd_ready;
  logic        o_icb_cmd_read;
  logic [31:0] o_icb_cmd_addr;
  logic [31:0] o_icb_cmd_wdata;
  logic [3:0]  o_icb_cmd_wmask;
  logic [1:0]  o_icb_cmd_size;
  logic        o_icb_rsp_valid;
  logic        o_icb_rsp_err;
  logic [31:0] o_icb_rsp_rdata;

  int n_vec;
  int n_mis;

  ux607_gnrl_icb32tobyte_split #(.AW(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_icb_cmd_valid (i_icb_cmd_valid),
    .i_icb_cmd_ready (i_icb_cmd_ready),
    .i_icb_cmd_read  (i_icb_cmd_read),
    .i_icb_cmd_addr  (i_icb_cmd_addr),
    .i_icb_cmd_wdata (i_icb_cmd_wdata),
    .i_icb_cmd_wmask (i_icb_cmd_wmask),
    .i_icb_cmd_size  (i_icb_cmd_size),
    .i_icb_rsp_valid (i_icb_rsp_valid),
    .i_icb_rsp_ready (i_icb_rsp_ready),
    .i_icb_rsp_err   (i_icb_rsp_err),
    .i_icb_rsp_rdata (i_icb_rsp_rdata),
    .o_icb_cmd_valid (o_icb_cmd_valid),
    .o_icb_cmd_ready (o_icb_cmd_ready),
    .o_icb_cmd_read  (o_icb_cmd_read),
    .o_icb_cmd_addr  (o_icb_cmd_addr),
    .o_icb_cmd_wdata (o_icb_cmd_wdata),
    .o_icb_cmd_wmask (o_icb_cmd_wmask),
    .o_icb_cmd_size  (o_icb_cmd_size),
    .o_icb_rsp_valid (o_icb_rsp_valid),
    .o_icb_rsp_err   (o_icb_rsp_err),
    .o_icb_rsp_rdata (o_icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic [31:0] dn_word;
    int          err_beat;
    int          exp_beats;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Idle downstream/upstream-response inputs with junk on the data lines.
  task automatic drive_noise();
    o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b0;
    o_icb_rsp_err   = 1'($urandom_range(0, 1));
    o_icb_rsp_rdata = $urandom;
    i_icb_rsp_ready = 1'b0;
  endtask

  // One upstream transaction driven through a scripted downstream responder.
  // stall_n / rsp_dly / rsp_hold < 0 pick random values; err_beat: -1 random,
  // -2 never, k only on beat k. The model is the ordered list of lanes the
  // access must touch, derived from size, alignment and mask.
  task automatic run_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [1:0] size, input int stall_n,
                         input int rsp_dly, input int rsp_hold, input int err_beat,
                         input logic use_word, input logic [31:0] dn_word,
                         output int beats, output logic [31:0] rdata, output logic err,
                         output int lat);
    int          lanes[$];
    int          nbytes;
    int          ln;
    int          cyc;
    int          stall_left;
    int          dly_left;
    int          d;
    int          h;
    logic [31:0] base;
    logic [31:0] exp_acc;
    logic        exp_err;
    logic [31:0] beat_word;
    logic        beat_err;
    logic        pend;
    logic        in_beat;
    logic        done;

    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base   = addr - (addr % nbytes);
    for (int k = 0; k < nbytes; k++) begin
      ln = int'(base % 4) + k;
      if (rd || wmask[ln]) lanes.push_back(ln);
    end
    exp_acc = 32'h0;
    exp_err = 1'b0;
    beats   = 0;
    rdata   = 32'h0;
    err     = 1'b0;
    lat     = -1;
    pend    = 1'b0;
    in_beat = 1'b0;
    done    = 1'b0;
    stall_left = 0;
    dly_left   = 0;
    beat_word  = 32'h0;
    beat_err   = 1'b0;

    @(negedge clk);
    drive_noise();
    check("idle_cmd_ready", 32'(i_icb_cmd_ready), 32'h1);
    i_icb_cmd_valid = 1'b1;
    i_icb_cmd_read  = rd;
    i_icb_cmd_addr  = addr;
    i_icb_cmd_wdata = wdata;
    i_icb_cmd_wmask = wmask;
    i_icb_cmd_size  = size;
    cyc = 0;

    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      i_icb_cmd_valid = 1'b0;
      i_icb_cmd_read  = 1'($urandom_range(0, 1));
      i_icb_cmd_addr  = $urandom;
      i_icb_cmd_wdata = $urandom;
      i_icb_cmd_wmask = 4'($urandom);
      i_icb_cmd_size  = 2'($urandom);
      drive_noise();
      if (i_icb_rsp_valid) begin
        lat   = cyc;
        rdata = i_icb_rsp_rdata;
        err   = i_icb_rsp_err;
        check("rsp_rdata", rdata, exp_acc);
        check("rsp_err", 32'(err), 32'(exp_err));
        check("beat_count", 32'(beats), 32'(lanes.size()));
        check("rsp_cmd_valid_low", 32'(o_icb_cmd_valid), 32'h0);
        check("rsp_cmd_ready_low", 32'(i_icb_cmd_ready), 32'h0);
        h = (rsp_hold < 0) ? int'($urandom_range(0, 4)) : rsp_hold;
        for (int j = 0; j < h; j++) begin
          @(negedge clk);
          drive_noise();
          check("hold_rsp_valid", 32'(i_icb_rsp_valid), 32'h1);
          check("hold_rsp_rdata", i_icb_rsp_rdata, rdata);
          check("hold_rsp_err", 32'(i_icb_rsp_err), 32'(err));
          check("hold_cmd_ready", 32'(i_icb_cmd_ready), 32'h0);
        end
        i_icb_rsp_ready = 1'b1;
        @(negedge clk);
        drive_noise();
        check("back_idle_ready", 32'(i_icb_cmd_ready), 32'h1);
        check("back_idle_rsp_valid", 32'(i_icb_rsp_valid), 32'h0);
        done = 1'b1;
      end else if (pend) begin
        check("wrsp_cmd_valid_low", 32'(o_icb_cmd_valid), 32'h0);
        o_icb_cmd_ready = 1'($urandom_range(0, 1));
        dly_left--;
        if (dly_left == 0) begin
          o_icb_rsp_valid = 1'b1;
          o_icb_rsp_rdata = beat_word;
          o_icb_rsp_err   = beat_err;
          pend = 1'b0;
        end
      end else if (o_icb_cmd_valid) begin
        if (beats >= lanes.size()) begin
          check("extra_beat", 32'(beats), 32'(lanes.size()));
          o_icb_cmd_ready = 1'b1;
          o_icb_rsp_valid = 1'b1;
          o_icb_rsp_err   = 1'b0;
        end else begin
          ln = lanes[beats];
          check("beat_addr", o_icb_cmd_addr, (base & 32'hFFFF_FFFC) + 32'(ln));
          check("beat_wmask", 32'(o_icb_cmd_wmask), 32'(1 << ln));
          check("beat_wdata", o_icb_cmd_wdata, wdata);
          check("beat_read", 32'(o_icb_cmd_read), 32'(rd));
          check("beat_size", 32'(o_icb_cmd_size), 32'h0);
          if (!in_beat) begin
            in_beat    = 1'b1;
            stall_left = (stall_n < 0) ? int'($urandom_range(0, 2)) : stall_n;
          end
          if (stall_left > 0) begin
            stall_left--;
            o_icb_rsp_valid = 1'($urandom_range(0, 1));
          end else begin
            in_beat         = 1'b0;
            o_icb_cmd_ready = 1'b1;
            beat_word = use_word ? dn_word : $urandom;
            beat_err  = (err_beat == -1) ? ($urandom_range(0, 3) == 0) : (err_beat == beats);
            if (rd) exp_acc[8*ln +: 8] = beat_word[8*ln +: 8];
            exp_err = exp_err | beat_err;
            beats++;
            d = (rsp_dly < 0) ? int'($urandom_range(0, 2)) : rsp_dly;
            if (d == 0) begin
              o_icb_rsp_valid = 1'b1;
              o_icb_rsp_rdata = beat_word;
              o_icb_rsp_err   = beat_err;
            end else begin
              pend     = 1'b1;
              dly_left = d;
            end
          end
        end
      end
    end

    if (!done) begin
      n_vec++;
      n_mis++;
      $display("FAIL txn_timeout: got no response after %0d cycles, required one", cyc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  int          beats;
  logic [31:0] rdata;
  logic        err;
  int          lat;

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    i_icb_cmd_valid = 1'b0;
    i_icb_cmd_read  = 1'b0;
    i_icb_cmd_addr  = 32'h0;
    i_icb_cmd_wdata = 32'h0;
    i_icb_cmd_wmask = 4'h0;
    i_icb_cmd_size  = 2'd0;
    i_icb_rsp_ready = 1'b0;
    o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b0;
    o_icb_rsp_err   = 1'b0;
    o_icb_rsp_rdata = 32'h0;

    //           rd    addr          wdata         wmask  sz    dn_word       eb  nb rdata         err lat
    vecs[0] = '{1'b1, 32'h1000_0002, 32'h0,        4'h0, 2'd2, 32'h4433_2211, -2, 4, 32'h4433_2211, 1'b0, 5};
    vecs[1] = '{1'b0, 32'h0000_0006, 32'hAABB_CCDD, 4'hC, 2'd1, 32'hFFFF_FFFF, -2, 2, 32'h0,        1'b0, 3};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h1234_5678, 4'h9, 2'd2, 32'hFFFF_FFFF, -2, 2, 32'h0,        1'b0, 3};
    vecs[3] = '{1'b0, 32'h0000_0200, 32'h1234_5678, 4'h0, 2'd2, 32'hFFFF_FFFF, -2, 0, 32'h0,        1'b0, 1};
    vecs[4] = '{1'b1, 32'h0000_0003, 32'h0,        4'h0, 2'd0, 32'hFF5A_FFFF, -2, 1, 32'hFF00_0000, 1'b0, 2};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h0,        4'h0, 2'd2, 32'h89AB_CDEF,  2, 4, 32'h89AB_CDEF, 1'b1, 5};
    vecs[6] = '{1'b1, 32'h0000_0041, 32'h0,        4'h0, 2'd3, 32'h0102_0304, -2, 4, 32'h0102_0304, 1'b0, 5};
    vecs[7] = '{1'b1, 32'h0000_0003, 32'h0,        4'h0, 2'd1, 32'hA1B2_C3D4, -2, 2, 32'hA1B2_0000, 1'b0, 3};
    vecs[8] = '{1'b0, 32'h0000_0005, 32'h0000_5500, 4'h2, 2'd0, 32'hFFFF_FFFF,  0, 1, 32'h0,        1'b1, 2};
    vecs[9] = '{1'b0, 32'h0000_0005, 32'h0000_5500, 4'h1, 2'd0, 32'hFFFF_FFFF, -2, 0, 32'h0,        1'b0, 1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(i_icb_cmd_ready), 32'h1);
    check("rst_o_cmd_valid", 32'(o_icb_cmd_valid), 32'h0);
    check("rst_rsp_valid", 32'(i_icb_rsp_valid), 32'h0);
    check("rst_o_addr", o_icb_cmd_addr, 32'h0);
    check("rst_o_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    check("rst_o_wdata", o_icb_cmd_wdata, 32'h0);
    check("rst_o_read", 32'(o_icb_cmd_read), 32'h0);
    check("rst_o_size", 32'(o_icb_cmd_size), 32'h0);
    check("rst_rsp_rdata", i_icb_rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(i_icb_rsp_err), 32'h0);
    rst = 1'b0;

    // Directed table with a combinationally acking downstream
    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].rd, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, vecs[v].size, 0, 0, 0,
              vecs[v].err_beat, 1'b1, vecs[v].dn_word, beats, rdata, err, lat);
      check($sformatf("vec%0d_beats", v), 32'(beats), 32'(vecs[v].exp_beats));
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
    end

    // Command stall of 3 cycles per beat and a 2-cycle response delay
    run_txn(1'b1, 32'h0000_0804, 32'h0, 4'h0, 2'd2, 3, 2, 0, -2, 1'b1, 32'hCAFE_F00D,
            beats, rdata, err, lat);
    check("stall_beats", 32'(beats), 32'h4);
    check("stall_rdata", rdata, 32'hCAFE_F00D);
    check("stall_latency", 32'(lat), 32'(4 * 6 + 1));

    // Upstream response backpressure for 4 cycles
    run_txn(1'b1, 32'h0000_0902, 32'h0, 4'h0, 2'd1, 0, 0, 4, -2, 1'b1, 32'h7766_5544,
            beats, rdata, err, lat);
    check("bp_rdata", rdata, 32'h7766_0000);

    // Reset in the middle of beat 2 of a word read
    @(negedge clk);
    i_icb_cmd_valid = 1'b1;
    i_icb_cmd_read  = 1'b1;
    i_icb_cmd_addr  = 32'h0000_0A00;
    i_icb_cmd_size  = 2'd2;
    o_icb_cmd_ready = 1'b1;
    o_icb_rsp_valid = 1'b1;
    o_icb_rsp_err   = 1'b0;
    o_icb_rsp_rdata = 32'h5555_5555;
    @(negedge clk);
    i_icb_cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_beat2_addr", o_icb_cmd_addr, 32'h0000_0A02);
    rst = 1'b1;
    #1;
    check("mid_rst_o_cmd_valid", 32'(o_icb_cmd_valid), 32'h0);
    check("mid_rst_rsp_valid", 32'(i_icb_rsp_valid), 32'h0);
    check("mid_rst_cmd_ready", 32'(i_icb_cmd_ready), 32'h1);
    check("mid_rst_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    check("mid_rst_rdata", i_icb_rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    o_icb_cmd_ready = 1'b0;
    o_icb_rsp_valid = 1'b0;
    run_txn(1'b0, 32'h0000_0B00, 32'hDEAD_BEEF, 4'hF, 2'd2, 0, 0, 0, -2, 1'b1, 32'h0,
            beats, rdata, err, lat);
    check("post_rst_beats", 32'(beats), 32'h4);
    check("post_rst_latency", 32'(lat), 32'h5);

    // Randomized transactions with random stalls, delays, errors and backpressure
    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), 2'($urandom),
              -1, -1, -1, -1, 1'b0, 32'h0, beats, rdata, err, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
